// File: rtl/instr_sequencer_if.sv
// Instruction-issue bus between the sequencer and its programmer/CPU side.
// The step signal exists only when SEQ_SINGLE_STEP_EN is defined.
interface instr_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [8:0]        prog_wdata;
  logic              start;
`ifdef SEQ_SINGLE_STEP_EN
  logic              step;
`endif
  logic [8:0]        instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic              illegal;

`ifdef SEQ_SINGLE_STEP_EN
  modport master (
    input  prog_we,
    input  prog_addr,
    input  prog_wdata,
    input  start,
    input  step,
    output instr,
    output instr_valid,
    output pc,
    output busy,
    output done,
    output illegal
  );

  modport slave (
    output prog_we,
    output prog_addr,
    output prog_wdata,
    output start,
    output step,
    input  instr,
    input  instr_valid,
    input  pc,
    input  busy,
    input  done,
    input  illegal
  );
`else
  modport master (
    input  prog_we,
    input  prog_addr,
    input  prog_wdata,
    input  start,
    output instr,
    output instr_valid,
    output pc,
    output busy,
    output done,
    output illegal
  );

  modport slave (
    output prog_we,
    output prog_addr,
    output prog_wdata,
    output start,
    input  instr,
    input  instr_valid,
    input  pc,
    input  busy,
    input  done,
    input  illegal
  );
`endif
endinterface

// File: rtl/instr_sequencer.sv
// Program memory + PC stepper issuing one registered 9-bit word per clock.
// Optional single-step gating via SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int          ADDR_W  = 4,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic              CLK,
  input  logic              RST_N,
  instr_sequencer_if.master bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              end_q;
  logic [8:0]        instr_q;
  logic              valid_q;
  logic              done_q;
  logic              ill_q;

  logic [8:0]        mem_q [DEPTH];

  logic [8:0]        word;
  logic [2:0]        op;
  logic              adv;
  logic              fin;
  logic              bad;
  logic              last;
  logic [ADDR_W-1:0] pc_inc;

  assign word   = mem_q[pc_q];
  assign op     = word[8:6];
  assign last   = (pc_q == ADDR_W'(DEPTH - 1));
  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef SEQ_SINGLE_STEP_EN
  assign adv = bus.step;
`else
  assign adv = 1'b1;
`endif

  // end_q marks that the top word was consumed and pc has wrapped
  assign fin = end_q || (op == HALT_OP);
  assign bad = !fin && ((op == 3'b011) || (op == 3'b101));

  always_ff @(posedge CLK) begin
    if ((state_q != S_RUN) && bus.prog_we) begin
      mem_q[bus.prog_addr] <= bus.prog_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      end_q   <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          instr_q <= '0;
          valid_q <= 1'b0;
          if (adv) begin
            unique case (1'b1)
              fin: begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                end_q   <= 1'b0;
                if (end_q) begin
                  pc_q <= '0;
                end
              end
              bad: begin
                ill_q <= 1'b1;
                pc_q  <= pc_inc;
                end_q <= last;
              end
              default: begin
                instr_q <= word;
                valid_q <= 1'b1;
                pc_q    <= pc_inc;
                end_q   <= last;
              end
            endcase
          end
        end
        default: begin
          instr_q <= '0;
          valid_q <= 1'b0;
          if (bus.start) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            end_q   <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = done_q;
  assign bus.illegal     = ill_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer against an address-walk reference.
// Build with SEQ_SINGLE_STEP_EN to exercise step gating.
module tb_instr_sequencer;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;

  always #5 CLK = ~CLK;

  instr_sequencer_if #(.ADDR_W(4)) bus();

  instr_sequencer #(
    .ADDR_W (4),
    .HALT_OP(3'b111)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  typedef struct {
    logic [8:0] instr;
    logic       valid;
    logic [3:0] pc;
    logic       busy;
    logic       done;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference: program image and run position as a plain address index 0..16
  logic [8:0] prog [16];
  int         m_st;
  int         m_a;
  int         m_pc;
  logic [8:0] m_instr;
  bit         m_valid;
  bit         m_done;
  bit         m_ill;
  int         ncyc;

  function automatic exp_t cur();
    exp_t e;
    e.instr = m_instr;
    e.valid = m_valid;
    e.pc    = 4'(m_pc);
    e.busy  = (m_st == 1);
    e.done  = m_done;
    e.ill   = m_ill;
    return e;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_a = 0; m_pc = 0;
    m_instr = '0; m_valid = 0; m_done = 0; m_ill = 0;
  endfunction

  function automatic void model_finish(int pcv);
    m_st = 2; m_done = 1; m_pc = pcv;
    m_instr = '0; m_valid = 0;
  endfunction

  function automatic void model_edge(bit we, logic [3:0] a,
                                     logic [8:0] d, bit st, bit stp);
    logic [8:0] w;
    if (m_st != 1) begin
      if (we) prog[a] = d;
      if (st) begin
        m_st = 1; m_a = 0; m_pc = 0; m_ill = 0; m_done = 0;
      end
      m_instr = '0; m_valid = 0;
    end else if (!stp) begin
      m_instr = '0; m_valid = 0;
    end else if (m_a == 16) begin
      model_finish(0);
    end else begin
      w = prog[m_a];
      if (w[8:6] == 3'b111) begin
        model_finish(m_a);
      end else begin
        if (w[8:6] == 3'b011 || w[8:6] == 3'b101) begin
          m_ill = 1; m_instr = '0; m_valid = 0;
        end else begin
          m_instr = w; m_valid = 1;
        end
        m_a  = m_a + 1;
        m_pc = m_a % 16;
      end
    end
  endfunction

  task automatic check_now(string nm, exp_t e);
    checks++;
    if (bus.instr !== e.instr || bus.instr_valid !== e.valid ||
        bus.pc !== e.pc || bus.busy !== e.busy ||
        bus.done !== e.done || bus.illegal !== e.ill) begin
      errors++;
      $display("FAIL %s @%0t: got instr=%b v=%b pc=%0d busy=%b done=%b ill=%b, expected instr=%b v=%b pc=%0d busy=%b done=%b ill=%b",
               nm, $time, bus.instr, bus.instr_valid, bus.pc, bus.busy,
               bus.done, bus.illegal, e.instr, e.valid, e.pc, e.busy,
               e.done, e.ill);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_now("cycle", e);
    end
  end

  task automatic cyc(bit we, logic [3:0] a, logic [8:0] d, bit st, bit stp);
    bit se;
    bus.prog_we    = we;
    bus.prog_addr  = a;
    bus.prog_wdata = d;
    bus.start      = st;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step = stp;
    se = stp;
`else
    se = 1'b1;
`endif
    @(posedge CLK);
    model_edge(we, a, d, st, se);
    exp_q.push_back(cur());
    #1;
  endtask

  function automatic bit step_pat(int n);
`ifdef SEQ_SINGLE_STEP_EN
    return (n % 3 == 2);
`else
    return n >= 0;
`endif
  endfunction

  task automatic load(logic [8:0] words [16]);
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), words[i], 1'b0, 1'b0);
  endtask

  task automatic run_prog(bit noise);
    int n;
    bit we;
    bit st;
    cyc(1'b0, 4'd0, 9'd0, 1'b1, 1'b0);
    n = 0;
    while (m_st == 1 && n < 200) begin
      we = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      st = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc(we, 4'($urandom_range(0, 15)), 9'($urandom), st, step_pat(n));
      n++;
    end
    checks++;
    if (m_st == 1) begin
      errors++;
      $display("FAIL run_bound: run still active after %0d cycles, required done", n);
    end
    cyc(1'b0, 4'd0, 9'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 9'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      @(negedge CLK);
      k++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries pending, required 0", exp_q.size());
    end
  endtask

  logic [8:0] img [16];

  initial begin
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_wdata = '0;
    bus.start      = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    bus.step = 1'b0;
`endif
    model_reset();
    #2 RST_N = 1'b0;
    #1 check_now("reset_state", cur());
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // demo program
    img = '{9'b100111110, 9'b100100011, 9'b000101101, 9'b110011011,
            9'b010101101, 9'b110110110, 9'b001011011, 9'b111000000,
            9'b0, 9'b0, 9'b0, 9'b0, 9'b0, 9'b0, 9'b0, 9'b0};
    load(img);
    run_prog(1'b0);
    checks++;
    if (m_pc != 7) begin
      errors++;
      $display("FAIL demo_halt_pc: model pc=%0d required 7", m_pc);
    end

    // illegal opcode skip, then illegal cleared by next start
    img[0] = 9'b101000000;
    img[1] = 9'b100000101;
    img[2] = 9'b111000000;
    load(img);
    run_prog(1'b0);
    img[0] = 9'b000000001;
    load(img);
    run_prog(1'b0);

    // full memory, no HALT: end-of-memory without wrap
    for (int i = 0; i < 16; i++) img[i] = 9'b010000000;
    load(img);
    run_prog(1'b0);

    // writes and starts during RUN are ignored
    img = '{9'b000000001, 9'b000000010, 9'b000000011, 9'b000000100,
            9'b111000000, 9'b0, 9'b0, 9'b0,
            9'b0, 9'b0, 9'b0, 9'b0, 9'b0, 9'b0, 9'b0, 9'b0};
    load(img);
    cyc(1'b0, 4'd0, 9'd0, 1'b1, 1'b0);
    for (int n = 0; n < 20 && m_st == 1; n++)
      cyc(1'b1, 4'd1, 9'b111000000, 1'b1, step_pat(n));
    cyc(1'b0, 4'd0, 9'd0, 1'b0, 1'b0);

    // asynchronous reset during the third issued word, then replay
    for (int i = 0; i < 16; i++) img[i] = 9'(i + 1);
    img[9] = 9'b111000000;
    load(img);
    cyc(1'b0, 4'd0, 9'd0, 1'b1, 1'b0);
    for (int n = 0; n < 40 && m_a < 3; n++)
      cyc(1'b0, 4'd0, 9'd0, 1'b0, step_pat(n));
    drain();
    RST_N = 1'b0;
    model_reset();
    #1 check_now("reset_midrun", cur());
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    run_prog(1'b0);

    // randomized programs with random ignored traffic during RUN
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) begin
        img[i] = 9'($urandom);
        if (img[i][8:6] == 3'b111 && $urandom_range(0, 1) == 1)
          img[i][8:6] = 3'b000;
      end
      load(img);
      run_prog(1'b1);
    end

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction-issue unit that drives the 9-bit instruction input of the 4-bit CPU core. It holds a small loadable program memory, steps a program counter, and presents one registered instruction per clock. Instructions change on the rising CLK edge and are stable when the CPU executes on the falling edge. The block is the producer side of the CPU's instruction interface, replacing hand-driven testbench stimulus.

## Interface
- ADDR_W, 4, program memory address width; depth is 2**ADDR_W words of 9 bits.
- HALT_OP, 3'b111, opcode (bits [8:6]) that terminates a run.
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- prog_we  input  1  program write strobe; honoured only outside RUN.
- prog_addr  input  ADDR_W  program write address.
- prog_wdata  input  9  program word; format is opcode[8:6], rs[5:4], rt[3:2], rd[1:0].
- start  input  1  begin execution at address 0; honoured only outside RUN.
- step  input  1  advance one instruction (present only with SEQ_SINGLE_STEP_EN).
- instr  output  9  instruction to the CPU; NOP (9'b000000000, AND $0,$0,$0) when not issuing.
- instr_valid  output  1  instr holds a program word.
- pc  output  ADDR_W  address of the next word to fetch.
- busy  output  1  state is RUN.
- done  output  1  last run completed; held until next start.
- illegal  output  1  sticky: an opcode of 011 or 101 was fetched during the current run.

## Operation
- States: IDLE, RUN, DONE. Reset: state IDLE, pc 0, instr NOP, instr_valid 0, busy 0, done 0, illegal 0. Program memory is not cleared by reset.
- Programming: in IDLE or DONE, prog_we writes prog_wdata to mem[prog_addr]. prog_we in RUN is ignored.
- IDLE/DONE + start: pc<=0, illegal<=0, done<=0, state<=RUN. A write and a start in the same cycle both take effect, and the written word is visible to the first fetch.
- RUN, each issuing cycle, with word w=mem[pc]:
  - If w[8:6]==HALT_OP: instr<=NOP, instr_valid<=0, state<=DONE, done<=1. The HALT word is not issued.
  - If w[8:6] is 011 or 101: instr<=NOP, instr_valid<=0, illegal<=1, pc<=pc+1, and the run continues.
  - Otherwise: instr<=w, instr_valid<=1, pc<=pc+1.
  - After issuing from address 2**ADDR_W-1 there is no wrap: on the next edge, instr<=NOP, instr_valid<=0, state<=DONE, done<=1, pc<=0.
- start in RUN is ignored. Leaving RUN always forces instr to NOP and instr_valid to 0 on the same edge.
- RST_N low at any time, including mid-run, forces all outputs to their reset values immediately, without waiting for a clock edge.

## Timing
- start sampled at rising edge k: busy=1 after edge k. mem[0] appears on instr after edge k+1 and is executed by the CPU at the falling edge within cycle k+1.
- Steady state: one instruction per cycle, with 1-cycle fetch latency from pc to instr.
- The HALT word at address h is seen at edge k+1+h; done=1 and busy=0 after that edge.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Program memory read is combinational from pc inside the block; writes are synchronous.

## Configuration
- SEQ_SINGLE_STEP_EN defined: the step port exists. In RUN, a word is issued only in cycles where step=1; in other cycles instr holds NOP with instr_valid=0 and pc holds. HALT and end-of-memory detection also require step. This guarantees the CPU re-executes nothing while paused.
- Undefined: no step port; RUN issues every cycle as described above.

## Test plan
- Load the CPU demo program, then pulse start. Program: 100111110, 100100011, 000101101, 110011011, 010101101, 110110110, 001011011, 111000000.
  - Required: instr shows the seven words on consecutive cycles with instr_valid=1.
  - Then instr=NOP, done=1, busy=0, pc=7.
  - CPU Write_Data sequence: 1111, 1000, 1000, 1001, 1000, 0001, 1001.
- mem[0]=101000000, mem[1]=100000101, mem[2]=111000000.
  - Required: first issued cycle is NOP with instr_valid=0 and illegal=1, then 100000101, then done.
  - illegal clears on the next start.
- Fill all 16 words with 010000000 and no HALT.
  - Required: 16 valid issues, then DONE with pc=0 and no wrap.
- Assert RST_N low during the third issued word.
  - Required: instr=NOP, instr_valid=0, busy=0, pc=0 immediately.
  - Memory contents are retained, and a later start replays from address 0.
- In RUN, pulse prog_we to address 1 and pulse start.
  - Required: both ignored; the run's issued stream and pc sequence are unchanged.
- With SEQ_SINGLE_STEP_EN defined, step=1 on every third cycle.
  - Required: exactly one valid word per step pulse; NOP with pc held otherwise.
